weight_mem_streamer: RTL and testbench
======================================

WEIGHT_MEM_STREAMER -- requirements
Module: weight_mem_streamer

Interface
REQ-001 Parameter ADDR_W, default 16, word-address width of the weight SRAM port.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  one clock; reset is synchronous and active-high.
REQ-004 mode_in  input  OP_MODE  layer mode; sampled only on an accepted start.
REQ-005 start  input  1  controller request to stream one filter set.
REQ-006 base_addr  input  ADDR_W  first SRAM word of the filter set; sampled only on an accepted start.
REQ-007 rd_en  output  1  SRAM read strobe; SRAM returns data exactly 1 cycle later.
REQ-008 rd_addr  output  ADDR_W  SRAM word address, valid while rd_en=1.
REQ-009 rd_data  input  64  SRAM read data, valid the cycle after rd_en.
REQ-010 mem_req  input  1  weight-buffer demand; a beat is accepted only when mem_data_valid=1 and mem_req=1 in the same cycle.
REQ-011 mem_data_valid  output  1  beat valid to the weight buffer.
REQ-012 weight_data  output  64  beat payload; equals rd_data when mem_data_valid=1, else 0.
REQ-013 busy  output  1  high from the cycle after an accepted start through the done cycle.
REQ-014 done  output  1  one-cycle pulse when all beats of the set have been accepted.

Function
REQ-015 The block SHALL implement FSM states IDLE, FETCH, DONE; IDLE->FETCH on start=1; FETCH->DONE when acc_cnt reaches TOTAL; DONE->IDLE unconditionally after one cycle.
REQ-016 On start in IDLE, the block SHALL latch mode, base_addr and TOTAL, and clear 7-bit counters iss_cnt and acc_cnt.
REQ-017 start SHALL be ignored in FETCH and DONE, with no change to latched values.
REQ-018 TOTAL SHALL be 88 for MODE1 and MODE2 (44 rows x 2 beats), 20 for MODE3, and 12 for MODE4.
REQ-019 rd_en SHALL equal (state==FETCH) and mem_req and (iss_cnt<TOTAL); rd_addr SHALL equal base_addr+iss_cnt, wrapping modulo 2^ADDR_W.
REQ-020 Each rd_en cycle SHALL increment iss_cnt by 1.
REQ-021 mem_data_valid SHALL be rd_en registered by one cycle, giving 1 cycle from rd_en to beat.
REQ-022 Each accepted beat (mem_data_valid and mem_req) SHALL increment acc_cnt by 1.
REQ-023 A beat presented while mem_req=0 is rejected: acc_cnt SHALL hold and iss_cnt SHALL be reloaded with acc_cnt, so the rejected word is re-read from the same address.
REQ-024 In the rejection cycle no new read SHALL issue (guaranteed by REQ-019, because mem_req=0).
REQ-025 If iss_cnt=TOTAL and the final beat is rejected, the rewind in REQ-023 SHALL reopen issue; no word SHALL be skipped or duplicated in the accepted stream.
REQ-026 The accepted beat sequence SHALL be exactly SRAM words base_addr+0 .. base_addr+TOTAL-1, in order.
REQ-027 done SHALL pulse in the cycle after the beat that makes acc_cnt=TOTAL, with state=DONE.
REQ-028 mem_data_valid SHALL be 0 in IDLE and DONE.

Reset
REQ-029 While rst_n=1, the block SHALL go to IDLE and drive rd_en=0, rd_addr=0, mem_data_valid=0, weight_data=0, busy=0, done=0, and clear both counters.
REQ-030 Reset asserted mid-stream SHALL abort the set with no further beats; the next start after reset releases SHALL begin from beat 0.

Verification
REQ-031 MODE4, base_addr=0x0100, start at cycle 0, mem_req held 1 -> reads at 0x0100..0x010B in cycles 1-12; beats in cycles 2-13; done=1 at cycle 14; busy low at cycle 15.
REQ-032 MODE1, base_addr=0, mem_req held 1 -> 88 beats in consecutive cycles carrying words 0..87; single done pulse; a second start during the stream is ignored.
REQ-033 MODE3 with mem_req=0 during the cycle of beat 10 -> beat 10 rejected; next read is address base+10; accepted stream is 0..19 with no gaps or duplicates; done after 20 accepted beats.
REQ-034 MODE2, base_addr=0xFFFE -> rd_addr sequence 0xFFFE, 0xFFFF, 0x0000, ...; 88 beats accepted.
REQ-035 MODE1 with rst_n=1 for one cycle at beat 30 -> the next cycle has mem_data_valid=0, busy=0, all outputs 0; a new start restarts at base_addr with acc_cnt=0.
REQ-036 MODE4 with mem_req low for 3 cycles spanning the final beat -> the last word (base+11) is re-read once and accepted; done pulses once.

Source files
------------

// File: rtl/weight_mem_streamer_if.sv
// Bus bundle between the weight streamer, the weight SRAM read port and the
// weight buffer.
//   rd_en / rd_addr  : SRAM read strobe and word address (streamer -> SRAM)
//   rd_data          : SRAM read data, one cycle after rd_en (SRAM -> streamer)
//   mem_req          : weight-buffer demand (buffer -> streamer)
//   mem_data_valid   : beat valid (streamer -> buffer)
//   weight_data      : beat payload (streamer -> buffer)
// master = streamer side, slave = SRAM/buffer side.
interface weight_mem_streamer_if #(
  parameter int ADDR_W = 16
);
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [63:0]       rd_data;
  logic              mem_req;
  logic              mem_data_valid;
  logic [63:0]       weight_data;

  modport master (
    output rd_en, rd_addr, mem_data_valid, weight_data,
    input  rd_data, mem_req
  );

  modport slave (
    input  rd_en, rd_addr, mem_data_valid, weight_data,
    output rd_data, mem_req
  );
endinterface

// File: rtl/weight_mem_streamer.sv
// Streams one filter set of 64-bit weight words from SRAM to the weight
// buffer. Reads issue while the buffer demands data; each read returns one
// cycle later as a beat. A beat the buffer refuses (mem_req low) rewinds the
// issue pointer to the accept pointer so the refused word is fetched again.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous reset, active HIGH despite the name
//   mode_in    : layer mode, 0=MODE1 1=MODE2 2=MODE3 3=MODE4 (sampled on start)
//   start      : begin a filter set (honoured only in IDLE)
//   base_addr  : first SRAM word of the set (sampled on start)
//   busy       : set in progress, cycle after start through the done cycle
//   done       : one-cycle pulse after the last beat is accepted
//   bus        : SRAM read port and weight-buffer stream (master modport)
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing reads and presenting beats
// DONE  | all beats accepted, done pulse
module weight_mem_streamer #(
  parameter int ADDR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode_in,
  input  logic               start,
  input  logic [ADDR_W-1:0]  base_addr,
  output logic               busy,
  output logic               done,
  weight_mem_streamer_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] base_q;
  logic [6:0]        iss_cnt;
  logic [6:0]        acc_cnt;
  logic [6:0]        total;
  logic              valid_q;
  logic              rd_en_int;
  logic              beat_valid;
  logic              accept;
  logic              reject;
  logic              start_acc;

  // Beats per set: MODE1/MODE2 are 44 rows of 2 beats.
  always_comb begin
    total = 7'd12;
    case (mode_q)
      2'd0, 2'd1: total = 7'd88;
      2'd2:       total = 7'd20;
      default:    total = 7'd12;
    endcase
  end

  // Outputs are gated by reset so they read zero for the whole reset cycle,
  // not just from the edge after it.
  assign rd_en_int  = !rst_n && (state_q == FETCH) && bus.mem_req && (iss_cnt < total);
  assign beat_valid = !rst_n && valid_q;
  assign accept     = beat_valid && bus.mem_req;
  assign reject     = beat_valid && !bus.mem_req;
  assign start_acc  = (state_q == IDLE) && start;

  assign bus.rd_en          = rd_en_int;
  assign bus.rd_addr        = rd_en_int ? (base_q + ADDR_W'(iss_cnt)) : '0;
  assign bus.mem_data_valid = beat_valid;
  assign bus.weight_data    = beat_valid ? bus.rd_data : 64'd0;
  assign busy               = !rst_n && (state_q != IDLE);
  assign done               = !rst_n && (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst_n) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (accept && (acc_cnt == total - 7'd1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      mode_q  <= 2'd0;
      base_q  <= '0;
      iss_cnt <= 7'd0;
      acc_cnt <= 7'd0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_en_int;
      if (start_acc) begin
        mode_q  <= mode_in;
        base_q  <= base_addr;
        iss_cnt <= 7'd0;
        acc_cnt <= 7'd0;
      end else begin
        if (accept) acc_cnt <= acc_cnt + 7'd1;
        // A refused beat drops the in-flight read as well; restart issue at
        // the first word not yet accepted. rd_en is low in that cycle since
        // mem_req is low, so the two branches never collide.
        if (reject)         iss_cnt <= acc_cnt;
        else if (rd_en_int) iss_cnt <= iss_cnt + 7'd1;
      end
    end
  end

endmodule

// File: tb/tb_weight_mem_streamer.sv
module tb_weight_mem_streamer;
  localparam int ADDR_W = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        mode_in = 2'd0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy;
  logic              done;
  logic [31:0]       cyc32 = 32'd0;

  int checks = 0;
  int failures = 0;

  weight_mem_streamer_if #(.ADDR_W(ADDR_W)) bus ();

  weight_mem_streamer #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode_in   (mode_in),
    .start     (start),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .bus       (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mem_word(input logic [15:0] a);
    return {16'hC0DE, a, ~a, 16'h5A5A};
  endfunction

  // SRAM model: one-cycle read latency; junk on non-read cycles.
  always @(posedge clk) begin
    cyc32 <= cyc32 + 32'd1;
    if (bus.rd_en) bus.rd_data <= mem_word(bus.rd_addr);
    else           bus.rd_data <= {32'hBAD0_0BAD, cyc32};
  end

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] base;
    int          stall_k;    // beat index whose cycle starts the mem_req-low window, -1 none
    int          stall_len;  // cycles mem_req stays low
    int          start2;     // cycle of a second start pulse, -1 none
    int          total;      // expected accepted beats
    int          exp_done;   // cycle of the done pulse (start at cycle 0)
    int          exp_reads;  // expected rd_en cycles
  } vec_t;

  vec_t vecs[6];

  task automatic run_stream(input vec_t v, input string tag);
    int acc = 0;
    int reads = 0;
    int dcount = 0;
    int dcyc = -1;
    int data_err = 0;
    int addr_err = 0;
    int busy_err = 0;
    int idle_err = 0;
    int exp_off[$];
    if (v.stall_k < 0) begin
      for (int i = 0; i < v.total; i++) exp_off.push_back(i);
    end else begin
      for (int i = 0; i <= v.stall_k; i++) exp_off.push_back(i);
      for (int i = v.stall_k; i < v.total; i++) exp_off.push_back(i);
    end
    for (int c = 0; c < v.exp_done + 4; c++) begin
      @(negedge clk);
      start = (c == 0) || (c == v.start2);
      if (c == 0) begin
        mode_in   = v.mode;
        base_addr = v.base;
      end else if (c == v.start2) begin
        mode_in   = (v.mode == 2'd3) ? 2'd0 : 2'd3;
        base_addr = 16'h5000;
      end else begin
        mode_in   = ~v.mode;
        base_addr = 16'h7777;
      end
      bus.mem_req = !(v.stall_k >= 0 && c >= v.stall_k + 2 && c < v.stall_k + 2 + v.stall_len);
      #2;
      if (bus.rd_en) begin
        if (reads < exp_off.size()) begin
          if (bus.rd_addr !== 16'(v.base + exp_off[reads])) addr_err++;
        end else begin
          addr_err++;
        end
        reads++;
      end
      if (bus.mem_data_valid && bus.mem_req) begin
        if (bus.weight_data !== mem_word(16'(v.base + acc))) data_err++;
        acc++;
      end
      if (!bus.mem_data_valid && bus.weight_data !== 64'd0) idle_err++;
      if ((c == 0 || c >= v.exp_done) && bus.mem_data_valid) idle_err++;
      if (done) begin
        dcount++;
        if (dcyc < 0) dcyc = c;
      end
      if (busy !== (c >= 1 && c <= v.exp_done)) busy_err++;
    end
    start = 1'b0;
    check($sformatf("%s_beats", tag), acc, v.total);
    check($sformatf("%s_data_err", tag), data_err, 0);
    check($sformatf("%s_reads", tag), reads, v.exp_reads);
    check($sformatf("%s_addr_err", tag), addr_err, 0);
    check($sformatf("%s_done_cycle", tag), dcyc, v.exp_done);
    check($sformatf("%s_done_pulses", tag), dcount, 1);
    check($sformatf("%s_busy_err", tag), busy_err, 0);
    check($sformatf("%s_idle_err", tag), idle_err, 0);
  endtask

  initial begin
    int acc;
    vec_t v_after;

    //          mode   base      k   len start2 total done reads
    vecs[0] = '{2'd3, 16'h0100, -1, 0, -1,    12,   14,  12};
    vecs[1] = '{2'd0, 16'h0000, -1, 0, 40,    88,   90,  88};
    vecs[2] = '{2'd2, 16'h0040, 10, 1, -1,    20,   24,  21};
    vecs[3] = '{2'd1, 16'hFFFE, -1, 0, -1,    88,   90,  88};
    vecs[4] = '{2'd3, 16'h0AB0, 11, 3, -1,    12,   18,  13};
    vecs[5] = '{2'd2, 16'h1000,  0, 2, -1,    20,   25,  21};
    v_after = '{2'd3, 16'h0300, -1, 0, -1,    12,   14,  12};

    bus.mem_req = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("rst_ctrl", {bus.rd_en, bus.mem_data_valid, busy, done}, 0);
    check("rst_addr", bus.rd_addr, 0);
    check("rst_wdata", bus.weight_data, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("post_rst_ctrl", {bus.rd_en, bus.mem_data_valid, busy, done}, 0);

    for (int i = 0; i < 6; i++) run_stream(vecs[i], $sformatf("v%0d", i));

    // Reset pulse during beat 30 of a MODE1 stream.
    acc = 0;
    for (int c = 0; c <= 33; c++) begin
      @(negedge clk);
      start       = (c == 0);
      mode_in     = 2'd0;
      base_addr   = 16'h0200;
      bus.mem_req = 1'b1;
      rst_n       = (c == 32);
      #2;
      if (bus.mem_data_valid && bus.mem_req) acc++;
      if (c == 32) begin
        check("midrst_in_ctrl", {bus.rd_en, bus.mem_data_valid, busy, done}, 0);
        check("midrst_in_wdata", bus.weight_data, 0);
      end
      if (c == 33) begin
        check("midrst_after_ctrl", {bus.rd_en, bus.mem_data_valid, busy, done}, 0);
        check("midrst_after_addr", bus.rd_addr, 0);
        check("midrst_after_wdata", bus.weight_data, 0);
      end
    end
    start = 1'b0;
    check("midrst_beats_before", acc, 30);
    run_stream(v_after, "restart");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
